// File: rtl/fpcvt_seq_ctrl.sv
// fpcvt_seq_ctrl
//   Multi-cycle sequencer converting a 12-bit two's-complement sample into an
//   8-bit float {S, E[2:0], F[3:0]} with value F * 2^E.
//   Steps: sign/abs -> iterative leading-zero normalisation -> round -> saturate.
// Ports
//   clk, rst        clock, async active-high reset
//   in_valid/ready  input handshake (in_ready = IDLE)
//   d               12-bit sample, only sampled on the accept edge
//   out_valid/ready output handshake (out_valid = DONE)
//   S, E, F         result; updated only in ROUND, held otherwise
//   busy            state != IDLE
//   conv_count      completed output handshakes, wraps
module fpcvt_seq_ctrl #(
  parameter bit ROUND_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [2:0]       E,
  output logic [3:0]       F,
  output logic             busy,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS   = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [11:0]      r_d;
  logic             r_sgn;
  logic [10:0]      r_sh;
  logic [2:0]       r_ecnt;
  logic             r_S;
  logic [2:0]       r_E;
  logic [3:0]       r_F;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_hs;
  logic             w_norm_done;
  logic [11:0]      w_neg;
  logic [10:0]      w_mag;
  logic [3:0]       w_f;
  logic             w_r;
  logic [3:0]       w_F;
  logic [2:0]       w_E;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_hs        = out_ready && (r_state == ST_DONE);
  assign w_norm_done = r_sh[10] || (r_ecnt == 3'd0);

  // -2048 has no positive 12-bit twin; clamp it to the largest magnitude.
  assign w_neg = -r_d;
  assign w_mag = (r_d == 12'h800) ? 11'h7FF :
                 (r_d[11] ? w_neg[10:0] : r_d[10:0]);

  // Round half-up on the bit just below F; a carry out of F renormalises
  // to 1000 with E+1, or saturates when E is already at its maximum.
  assign w_f = r_sh[10:7];
  assign w_r = r_sh[6] & ROUND_EN;

  always_comb begin
    w_F = w_f;
    w_E = r_ecnt;
    if (w_r) begin
      if (w_f != 4'hF) begin
        w_F = w_f + 4'd1;
      end else if (r_ecnt != 3'd7) begin
        w_F = 4'b1000;
        w_E = r_ecnt + 3'd1;
      end else begin
        w_F = 4'hF;
        w_E = 3'd7;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ABS;
      ST_ABS:   w_next = ST_NORM;
      ST_NORM:  if (w_norm_done) w_next = ST_ROUND;
      ST_ROUND: w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Datapath. The sign is parked in r_sgn so S only moves in ROUND,
  // keeping the previous result intact until the new one is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d    <= '0;
      r_sgn  <= 1'b0;
      r_sh   <= '0;
      r_ecnt <= '0;
      r_S    <= 1'b0;
      r_E    <= '0;
      r_F    <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_d   <= d;
        r_sgn <= d[11];
      end
      if (r_state == ST_ABS) begin
        r_sh   <= w_mag;
        r_ecnt <= 3'd7;
      end
      if ((r_state == ST_NORM) && !w_norm_done) begin
        r_sh   <= {r_sh[9:0], 1'b0};
        r_ecnt <= r_ecnt - 3'd1;
      end
      if (r_state == ST_ROUND) begin
        r_S <= r_sgn;
        r_E <= w_E;
        r_F <= w_F;
      end
      if (w_hs) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign S          = r_S;
  assign E          = r_E;
  assign F          = r_F;
  assign conv_count = r_cnt;

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
module tb_fpcvt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [11:0] d = '0;
  logic        in_ready, out_valid, S, busy;
  logic [2:0]  E;
  logic [3:0]  F;
  logic [15:0] conv_count;

  // Truncating instance for the ROUND_EN=0 checks
  logic        in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [11:0] d0 = '0;
  logic        in_ready0, out_valid0, S0, busy0;
  logic [2:0]  E0;
  logic [3:0]  F0;
  logic [15:0] conv_count0;

  always #5 clk = ~clk;

  fpcvt_seq_ctrl #(.ROUND_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F),
    .busy(busy), .conv_count(conv_count));

  fpcvt_seq_ctrl #(.ROUND_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .d(d0),
    .out_valid(out_valid0), .out_ready(out_ready0), .S(S0), .E(E0), .F(F0),
    .busy(busy0), .conv_count(conv_count0));

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [11:0] d;
    int s, e, f, lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: float conversion from plain arithmetic on the magnitude.
  function automatic void model(input logic [11:0] dd, input bit ren,
                                output int s, output int e, output int f,
                                output int lat);
    int v, mag, p, e0, fq, r;
    v = $signed(dd);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    p = -1;
    for (int i = 0; i < 11; i++) if (((mag >> i) & 1) == 1) p = i;
    e0 = (p >= 3) ? p - 3 : 0;
    fq = mag >> e0;
    r  = (ren && e0 > 0) ? ((mag >> (e0 - 1)) & 1) : 0;
    lat = 4 + 7 - e0;
    s = dd[11];
    if (fq + r == 16) begin
      if (e0 < 7) begin e = e0 + 1; f = 8; end
      else        begin e = 7;      f = 15; end
    end else begin
      e = e0; f = fq + r;
    end
  endfunction

  // One conversion on the rounding instance. Latency counts the accept
  // cycle as 1. out_ready is withheld for 'hold' cycles in DONE.
  task automatic do_conv(input logic [11:0] dv, input int s, input int e,
                         input int f, input int lat, input int hold,
                         input string nm);
    int k;
    @(negedge clk);
    chk({nm, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    d = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d = 12'($urandom);
    k = 1;
    while (k < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      k++;
    end
    chk({nm, ".lat"}, k, lat);
    chk({nm, ".S"}, S, s);
    chk({nm, ".E"}, E, e);
    chk({nm, ".F"}, F, f);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || S !== 1'(s) || E !== 3'(e) || F !== 4'(f) ||
          in_ready !== 1'b0)
        chk({nm, ".hold"}, 0, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk({nm, ".vld_drop"}, out_valid, 0);
    chk({nm, ".count"}, conv_count, exp_cnt);
    chk({nm, ".S_keep"}, S, s);
  endtask

  vec_t vt[9];

  initial begin
    int s, e, f, lat;
    int k;

    vt[0] = '{12'h000, 0, 0, 0, 11};
    vt[1] = '{12'd422, 0, 5, 13, 6};
    vt[2] = '{12'hE5A, 1, 5, 13, 6};
    vt[3] = '{12'd63,  0, 3, 8, 9};
    vt[4] = '{12'h7FF, 0, 7, 15, 4};
    vt[5] = '{12'h800, 1, 7, 15, 4};
    vt[6] = '{12'd1,   0, 0, 1, 11};
    vt[7] = '{12'd15,  0, 0, 15, 11};
    vt[8] = '{12'd31,  0, 2, 8, 10};

    // Reset state
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.SEF", {S, E, F}, 0);
    chk("rst.count", conv_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 9; i++)
      do_conv(vt[i].d, vt[i].s, vt[i].e, vt[i].f, vt[i].lat, i % 3,
              $sformatf("vec%0d", i));

    // Random vectors against the model
    for (int i = 0; i < 40; i++) begin
      logic [11:0] rv;
      rv = 12'($urandom);
      if (i % 8 == 0) rv = 12'($urandom_range(0, 15));
      model(rv, 1'b1, s, e, f, lat);
      do_conv(rv, s, e, f, lat, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    // Backpressure: 5 cycles in DONE with stray in_valid pulses
    @(negedge clk);
    in_valid = 1'b1; d = 12'd422;
    @(posedge clk); #1; in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp.reach_done", out_valid, 1);
    for (int h = 0; h < 5; h++) begin
      in_valid = h[0];
      d = 12'h7FF;
      @(posedge clk);
      @(negedge clk);
      chk("bp.vld", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.SEF", {S, E, F}, {1'b0, 3'd5, 4'd13});
      chk("bp.count", conv_count, exp_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("bp.count_rel", conv_count, exp_cnt);
    chk("bp.idle", in_ready, 1);
    chk("bp.SEF_keep", {S, E, F}, {1'b0, 3'd5, 4'd13});

    // Reset while d=1 is normalising
    in_valid = 1'b1; d = 12'd1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rn.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rn.out_valid", out_valid, 0);
    chk("rn.in_ready", in_ready, 1);
    chk("rn.count", conv_count, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    do_conv(12'd422, 0, 5, 13, 6, 1, "rn.after");

    // Truncating instance
    for (int i = 0; i < 2; i++) begin
      logic [11:0] tv;
      tv = (i == 0) ? 12'd63 : 12'h7FF;
      @(negedge clk);
      in_valid0 = 1'b1; d0 = tv;
      @(posedge clk); #1; in_valid0 = 1'b0;
      k = 0;
      while (!out_valid0 && k < 20) begin @(negedge clk); k++; end
      chk("trunc.vld", out_valid0, 1);
      chk("trunc.E", E0, (i == 0) ? 2 : 7);
      chk("trunc.F", F0, 15);
      out_ready0 = 1'b1;
      @(posedge clk); #1; out_ready0 = 1'b0;
      @(negedge clk);
      chk("trunc.count", conv_count0, i + 1);
    end
    model(12'd63, 1'b0, s, e, f, lat);
    chk("trunc.model_vs_dut.E", E0, (e == 2) ? 7 : -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
